// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: data width, canonical NOP, fetch-stage
// state encoding and the {instruction, pc} entry carried by the fetch buffer.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH
    } if_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of {instruction, pc} entries.
// Flush has priority over a simultaneous push or pop.
module if_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Entry storage write
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers responses with their PCs and presents them to decode (valid/ready).
// Redirects flush the buffer and kill responses still in flight.
// Optional macro IF_FETCH_BYPASS_EN: present a response combinationally when
// the buffer is empty (gnt-to-valid latency 1 instead of 2).
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [31:0] pc_out
);

    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    if_state_t       state, state_next;
    logic [31:0]     pc;
    logic [31:0]     resp_pc;
    logic [31:0]     redirect_target;
    logic [CW-1:0]   outstanding, outstanding_next;
    logic [CW-1:0]   kill, kill_next;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic            fire_req;
    logic            resp_live;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    fetch_entry_t    push_data;
    fetch_entry_t    head;
    logic            unused_bits;

    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign unused_bits     = ^{redirect_pc[1:0], fifo_full};

    // A pop this cycle frees a slot, so the request may be issued without
    // waiting a cycle; this is what keeps one instruction per cycle flowing.
    assign pop      = !fifo_empty && id_ready;
    assign in_use   = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(pop);
    assign imem_req = (state == RUN) && (in_use < DEPTH_LIM);
    assign imem_addr = pc;
    assign fire_req = imem_req && imem_gnt;

    // A response arriving with a redirect is dropped along with the killed ones.
    assign resp_live = imem_rvalid && (kill == '0) && !redirect_valid;
    assign push_data = '{instr: imem_rdata, pc: resp_pc};

`ifdef IF_FETCH_BYPASS_EN
    logic bypass;
    assign bypass      = resp_live && fifo_empty;
    assign push        = resp_live && !(bypass && id_ready);
    assign if_valid    = !fifo_empty || bypass;
    assign instruction = !fifo_empty ? head.instr : (bypass ? imem_rdata : NOP_INSTR);
    assign pc_out      = !fifo_empty ? head.pc    : (bypass ? resp_pc    : '0);
`else
    assign push        = resp_live;
    assign if_valid    = !fifo_empty;
    assign instruction = !fifo_empty ? head.instr : NOP_INSTR;
    assign pc_out      = !fifo_empty ? head.pc    : '0;
`endif

    // In-flight accounting; on redirect every remaining response becomes a kill
    always_comb begin
        outstanding_next = outstanding + CW'(fire_req) - CW'(imem_rvalid);
        kill_next        = kill;
        if (redirect_valid)
            kill_next = outstanding_next;
        else if (imem_rvalid && (kill != '0))
            kill_next = kill - CW'(1);
    end

    // Next-state selection for BOOT/RUN/FLUSH
    always_comb begin
        state_next = state;
        case (state)
            BOOT: state_next = RUN;
            RUN, FLUSH: begin
                if (redirect_valid)
                    state_next = (outstanding_next != '0) ? FLUSH : RUN;
                else if ((state == FLUSH) && (kill_next == '0))
                    state_next = RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_next;
    end

    // Fetch PC, response PC tracker and in-flight counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            kill        <= '0;
        end else begin
            outstanding <= outstanding_next;
            kill        <= kill_next;
            if (redirect_valid) begin
                pc      <= redirect_target;
                resp_pc <= redirect_target;
            end else begin
                if (fire_req)  pc      <= pc + 32'd4;
                if (resp_live) resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    if_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model with variable latency and random
// grant, plus a stream-level reference (next fetch address, next delivered PC,
// number of stale responses still due after a redirect).
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 2;
    localparam logic [31:0] MAGIC  = 32'hA5A5_0000;
`ifdef IF_FETCH_BYPASS_EN
    localparam int LAT_EXP = 1;
`else
    localparam int LAT_EXP = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_out;

    if_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .instruction    (instruction),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // memory model: in-order pending requests with their due cycle
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          last_due;
    int          mem_lat;
    int          gnt_pct;

    // stream reference
    logic [31:0] exp_fetch;
    logic [31:0] exp_deliver;
    int          stale;
    int          n_accept;

    // per-cycle samples
    logic        s_req, s_gnt, s_rvalid, s_valid, s_acc;
    logic [31:0] s_addr, s_pc, s_instr;

    task automatic tick();
        int          due;
        logic [31:0] junk_a;
        int          junk_d;
        logic [31:0] tgt;
        imem_gnt    = ($urandom_range(0, 99) < gnt_pct);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr[0] ^ MAGIC;
        end
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_gnt    = imem_req && imem_gnt;
        s_rvalid = imem_rvalid;
        s_valid  = if_valid;
        s_pc     = pc_out;
        s_instr  = instruction;
        s_acc    = if_valid && id_ready;

        if (stale > 0) begin
            tests_run++;
            if (s_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_req: cycle %0d imem_req=%b required 0 (%0d stale due)", cyc, s_req, stale);
            end
        end
        if (s_gnt) begin
            tests_run++;
            if (s_addr !== exp_fetch) begin
                tests_failed++;
                $display("FAIL fetch_addr: cycle %0d imem_addr=%h required %h", cyc, s_addr, exp_fetch);
            end
        end
        if (!s_valid) begin
            tests_run++;
            if (s_instr !== NOP_INSTR) begin
                tests_failed++;
                $display("FAIL nop_when_empty: cycle %0d instruction=%h required %h", cyc, s_instr, NOP_INSTR);
            end
        end
        if (s_acc) begin
            tests_run++;
            if (s_pc !== exp_deliver || s_instr !== (exp_deliver ^ MAGIC)) begin
                tests_failed++;
                $display("FAIL deliver: cycle %0d pc_out=%h instruction=%h required pc %h instruction %h",
                         cyc, s_pc, s_instr, exp_deliver, exp_deliver ^ MAGIC);
            end
        end

        if (s_rvalid) begin
            junk_a = pend_addr.pop_front();
            junk_d = pend_due.pop_front();
            if (stale > 0) stale--;
        end
        if (s_gnt) begin
            due = cyc + mem_lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(s_addr);
            pend_due.push_back(due);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (s_acc) begin
            exp_deliver = exp_deliver + 32'd4;
            n_accept++;
        end
        if (redirect_valid) begin
            tgt         = {redirect_pc[31:2], 2'b00};
            exp_fetch   = tgt;
            exp_deliver = tgt;
            stale       = pend_addr.size();
        end
        tests_run++;
        if (pend_addr.size() > DEPTH) begin
            tests_failed++;
            $display("FAIL outstanding_bound: cycle %0d outstanding=%0d required <= %0d", cyc, pend_addr.size(), DEPTH);
        end

        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        cyc++;
    endtask

    task automatic model_reset();
        pend_addr.delete();
        pend_due.delete();
        stale       = 0;
        last_due    = cyc;
        exp_fetch   = RST_PC;
        exp_deliver = RST_PC;
    endtask

    task automatic apply_reset();
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] g_addr[$];
        int          g_k[$];
        int          fv;
        int          vrun;
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        mem_lat = 1; gnt_pct = 100;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || instruction !== NOP_INSTR || pc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: req=%b valid=%b instr=%h pc=%h required 0 0 %h 0",
                     imem_req, if_valid, instruction, pc_out, NOP_INSTR);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (s_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_no_req: imem_req=%b required 0", s_req);
        end
        fv = -1; vrun = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (s_gnt) begin g_addr.push_back(s_addr); g_k.push_back(k); end
            if (s_valid && fv < 0) fv = k;
            if (fv >= 0 && s_valid) vrun++;
        end
        tests_run++;
        if (g_addr.size() < 3 || fv < 0) begin
            tests_failed++;
            $display("FAIL stream_start: grants=%0d first_valid=%0d required >=3 and >=1", g_addr.size(), fv);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (g_addr[i] !== RST_PC + 32'(4 * i) || g_k[i] != g_k[0] + i) begin
                    tests_failed++;
                    $display("FAIL first_fetches: grant %0d addr=%h at %0d required %h at %0d",
                             i, g_addr[i], g_k[i], RST_PC + 32'(4 * i), g_k[0] + i);
                end
            end
            tests_run++;
            if (fv - g_k[0] != LAT_EXP) begin
                tests_failed++;
                $display("FAIL gnt_to_valid: latency=%0d required %0d", fv - g_k[0], LAT_EXP);
            end
            tests_run++;
            if (vrun != 12 - fv + 1) begin
                tests_failed++;
                $display("FAIL throughput: valid cycles=%0d required %0d", vrun, 12 - fv + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int held_bad;
        int acc0;
        apply_reset();
        id_ready = 1'b0; mem_lat = 1; gnt_pct = 100;
        held_bad = 0;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            if (s_valid && s_pc !== RST_PC) held_bad++;
        end
        tests_run++;
        if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== RST_PC || held_bad != 0) begin
            tests_failed++;
            $display("FAIL backpressure_hold: req=%b valid=%b pc_out=%h changes=%0d required 0 1 %h 0",
                     s_req, s_valid, s_pc, held_bad, RST_PC);
        end
        id_ready = 1'b1;
        acc0 = n_accept;
        repeat (20) tick();
        tests_run++;
        if (n_accept - acc0 < 15) begin
            tests_failed++;
            $display("FAIL backpressure_resume: accepted=%0d required >= 15", n_accept - acc0);
        end
    endtask

    task automatic test_redirect_flush();
        int          nreq0;
        logic [31:0] gaddr;
        logic [31:0] vpc;
        logic        got_g;
        logic        got_v;
        apply_reset();
        id_ready = 1'b1; mem_lat = 3; gnt_pct = 100;
        for (int k = 0; k < 10 && pend_addr.size() < 2; k++) tick();
        tests_run++;
        if (pend_addr.size() != 2) begin
            tests_failed++;
            $display("FAIL flush_setup: outstanding=%0d required 2", pend_addr.size());
        end
        redirect_pc = 32'h0000_2002; redirect_valid = 1'b1;
        tick();
        nreq0 = 0; got_g = 1'b0; got_v = 1'b0; gaddr = '0; vpc = '0;
        for (int k = 0; k < 30 && !got_v; k++) begin
            tick();
            if (!got_g && !s_req) nreq0++;
            if (!got_g && s_gnt) begin got_g = 1'b1; gaddr = s_addr; end
            if (!got_v && s_valid) begin got_v = 1'b1; vpc = s_pc; end
        end
        tests_run++;
        if (nreq0 < 2) begin
            tests_failed++;
            $display("FAIL flush_cycles: idle=%0d required >= 2", nreq0);
        end
        tests_run++;
        if (!got_g || gaddr !== 32'h0000_2000) begin
            tests_failed++;
            $display("FAIL redirect_fetch: addr=%h required 00002000", gaddr);
        end
        tests_run++;
        if (!got_v || vpc !== 32'h0000_2000) begin
            tests_failed++;
            $display("FAIL redirect_deliver: pc_out=%h required 00002000", vpc);
        end
    endtask

    task automatic test_redirect_pop();
        int acc0;
        apply_reset();
        id_ready = 1'b1; mem_lat = 1; gnt_pct = 100;
        repeat (8) tick();
        acc0 = n_accept;
        redirect_pc = 32'h0000_0300; redirect_valid = 1'b1;
        tick();
`ifndef IF_FETCH_BYPASS_EN
        tests_run++;
        if (!(s_valid && s_rvalid) || n_accept != acc0 + 1) begin
            tests_failed++;
            $display("FAIL redirect_pop: valid=%b rvalid=%b accepted=%0d required 1 1 1",
                     s_valid, s_rvalid, n_accept - acc0);
        end
`endif
        tick();
        tests_run++;
        if (s_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_empty: if_valid=%b required 0", s_valid);
        end
        acc0 = n_accept;
        repeat (10) tick();
        tests_run++;
        if (n_accept - acc0 < 5) begin
            tests_failed++;
            $display("FAIL redirect_restart: accepted=%0d required >= 5", n_accept - acc0);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] g[$];
        id_ready = 1'b1; mem_lat = 1; gnt_pct = 100;
        redirect_pc = 32'hFFFF_FFFC; redirect_valid = 1'b1;
        tick();
        for (int k = 0; k < 20 && g.size() < 2; k++) begin
            tick();
            if (s_gnt) g.push_back(s_addr);
        end
        tests_run++;
        if (g.size() < 2 || g[0] !== 32'hFFFF_FFFC || g[1] !== 32'h0000_0000) begin
            tests_failed++;
            $display("FAIL pc_wrap: grants=%0d first=%h second=%h required fffffffc 00000000",
                     g.size(), (g.size() > 0) ? g[0] : 32'hx, (g.size() > 1) ? g[1] : 32'hx);
        end
        repeat (6) tick();
    endtask

    task automatic test_async_reset();
        int acc0;
        apply_reset();
        id_ready = 1'b1; mem_lat = 3; gnt_pct = 100;
        repeat (6) tick();
        for (int k = 0; k < 10 && pend_addr.size() < 2; k++) tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || instruction !== NOP_INSTR || pc_out !== 32'h0) begin
            tests_failed++;
            $display("FAIL async_reset: req=%b valid=%b instr=%h pc=%h required 0 0 %h 0",
                     imem_req, if_valid, instruction, pc_out, NOP_INSTR);
        end
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (s_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_boot: imem_req=%b required 0", s_req);
        end
        tick();
        tests_run++;
        if (!s_gnt || s_addr !== RST_PC) begin
            tests_failed++;
            $display("FAIL async_restart: gnt=%b addr=%h required 1 %h", s_gnt, s_addr, RST_PC);
        end
        acc0 = n_accept;
        repeat (10) tick();
        tests_run++;
        if (n_accept == acc0) begin
            tests_failed++;
            $display("FAIL async_stream: accepted=%0d required > 0", n_accept - acc0);
        end
    endtask

    task automatic test_random();
        int acc0;
        apply_reset();
        gnt_pct = 70;
        acc0 = n_accept;
        for (int k = 0; k < 1500; k++) begin
            id_ready = ($urandom_range(0, 9) < 7);
            mem_lat  = $urandom_range(1, 3);
            if ($urandom_range(0, 99) < 3) begin
                redirect_pc    = $urandom();
                redirect_valid = 1'b1;
            end
            tick();
        end
        tests_run++;
        if (n_accept - acc0 < 100) begin
            tests_failed++;
            $display("FAIL random_progress: accepted=%0d required >= 100", n_accept - acc0);
        end
    endtask

    initial begin
        n_accept = 0;
        test_reset();
        test_backpressure();
        test_redirect_flush();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
